execute_stage: RTL

- Pipeline stage directly downstream of instruction decode.
- Consumes decode's registered controls, operands, sign-extended immediate, PC and candidate destination registers.
- Performs the ALU operation, selects the destination register and computes the branch target, then registers everything for memory access.
- Multiply (funct 0x18) runs as a 32-iteration shift-add sequence and stalls upstream until it completes.

---
 rtl/execute_stage.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// Execute stage: ALU, destination select, branch target and a
// shift-add multiplier that stalls upstream until the product is ready.
module execute_stage #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       writeBackControlIn,
    input  logic [2:0]       memAccessControlIn,
    input  logic [3:0]       calculationControl,
    input  logic [WIDTH-1:0] programCounterIn,
    input  logic [WIDTH-1:0] readData1,
    input  logic [WIDTH-1:0] readData2,
    input  logic [WIDTH-1:0] immediateOperand,
    input  logic [4:0]       writeRegister0,
    input  logic [4:0]       writeRegister1,
    output logic             stall,
    output logic [1:0]       writeBackControlOut,
    output logic [2:0]       memAccessControlOut,
    output logic [WIDTH-1:0] aluResult,
    output logic [WIDTH-1:0] storeData,
    output logic [4:0]       destRegister,
    output logic [WIDTH-1:0] branchTarget,
    output logic             zero
);

    localparam int CW = $clog2(MUL_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t state, stateNext;

    logic             aluSrc;
    logic             regDst;
    logic [1:0]       aluClass;
    logic [5:0]       funct;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] aluOut;
    logic [WIDTH-1:0] target;
    logic [4:0]       dest;
    logic             isMult;
    logic             lastIter;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] product;
    logic [WIDTH-1:0] productNext;
    logic [CW-1:0]    count;

    logic [1:0]       wbSave;
    logic [2:0]       memSave;
    logic [4:0]       destSave;
    logic [WIDTH-1:0] storeSave;
    logic [WIDTH-1:0] targetSave;

    assign aluSrc   = calculationControl[3];
    assign regDst   = calculationControl[2];
    assign aluClass = calculationControl[1:0];
    assign funct    = immediateOperand[5:0];
    assign shamt    = immediateOperand[10:6];
    assign opB      = aluSrc ? immediateOperand : readData2;
    assign dest     = regDst ? writeRegister1 : writeRegister0;
    assign target   = programCounterIn + (immediateOperand << 2);
    assign isMult   = (aluClass == 2'b10) && (funct == 6'h18);
    assign lastIter = (count == LAST);

    assign productNext = product + (mplier[0] ? mcand : '0);

    // ALU result for single-cycle operations
    always_comb begin
        aluOut = '0;
        unique case (aluClass)
            2'b00: aluOut = readData1 + opB;
            2'b01: aluOut = readData1 - opB;
            2'b11: aluOut = readData1 + opB;
            2'b10: begin
                unique case (funct)
                    6'h20:   aluOut = readData1 + opB;
                    6'h22:   aluOut = readData1 - opB;
                    6'h24:   aluOut = readData1 & opB;
                    6'h25:   aluOut = readData1 | opB;
                    6'h2A:   aluOut = {{(WIDTH-1){1'b0}},
                                      $signed(readData1) < $signed(opB)};
                    6'h00:   aluOut = readData2 << shamt;
                    default: aluOut = '0;
                endcase
            end
            default: aluOut = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // Next state and stall; stall drops in the final multiply cycle
    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        unique case (state)
            IDLE: begin
                if (isMult) begin
                    stateNext = MUL;
                    stall     = rst_n;
                end
            end
            MUL: begin
                stall = rst_n && !lastIter;
                if (lastIter) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Multiplier datapath and registered pipeline outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand               <= '0;
            mplier              <= '0;
            product             <= '0;
            count               <= '0;
            wbSave              <= '0;
            memSave             <= '0;
            destSave            <= '0;
            storeSave           <= '0;
            targetSave          <= '0;
            writeBackControlOut <= '0;
            memAccessControlOut <= '0;
            aluResult           <= '0;
            storeData           <= '0;
            destRegister        <= '0;
            branchTarget        <= '0;
            zero                <= 1'b0;
        end else if (state == IDLE) begin
            if (isMult) begin
                mcand               <= readData1;
                mplier              <= readData2;
                product             <= '0;
                count               <= '0;
                wbSave              <= writeBackControlIn;
                memSave             <= memAccessControlIn;
                destSave            <= dest;
                storeSave           <= readData2;
                targetSave          <= target;
                writeBackControlOut <= '0;
                memAccessControlOut <= '0;
            end else begin
                writeBackControlOut <= writeBackControlIn;
                memAccessControlOut <= memAccessControlIn;
                aluResult           <= aluOut;
                storeData           <= readData2;
                destRegister        <= dest;
                branchTarget        <= target;
                zero                <= (aluOut == '0);
            end
        end else begin
            product <= productNext;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            count   <= count + CW'(1);
            if (lastIter) begin
                writeBackControlOut <= wbSave;
                memAccessControlOut <= memSave;
                aluResult           <= productNext;
                storeData           <= storeSave;
                destRegister        <= destSave;
                branchTarget        <= targetSave;
                zero                <= (productNext == '0);
            end
        end
    end

endmodule
